// File: rtl/matriz_pkg.sv
// Shared constants and helpers for the parametrised LED-matrix puzzle core.
package matriz_pkg;

  localparam int unsigned DEF_ROWS  = 8;
  localparam int unsigned DEF_COLS  = 8;
  localparam int unsigned DEF_BTNS  = 8;
  localparam int unsigned DEF_ROW_W = $clog2(DEF_ROWS);
  localparam int unsigned DEF_MASK_W = DEF_BTNS * DEF_ROWS * DEF_COLS;

  // Button k owns the 3x3 tile at tile-row k/3, tile-col k%3 (edge tiles clipped).
  function automatic logic [DEF_MASK_W-1:0] def_masks();
    logic [DEF_MASK_W-1:0] m;
    m = '0;
    for (int k = 0; k < int'(DEF_BTNS); k++)
      for (int r = 0; r < int'(DEF_ROWS); r++)
        for (int c = 0; c < int'(DEF_COLS); c++)
          if ((r / 3 == k / 3) && (c / 3 == k % 3))
            m[k*int'(DEF_ROWS*DEF_COLS) + r*int'(DEF_COLS) + c] = 1'b1;
    return m;
  endfunction

  localparam logic [DEF_MASK_W-1:0] DEF_BTN_MASKS = def_masks();

  // Rows that must be lit to clear a level: min(rows, 2*lvl+1).
  function automatic int unsigned win_rows(input int unsigned rows, input int unsigned lvl);
    int unsigned req;
    req = 2 * lvl + 1;
    return (req < rows) ? req : rows;
  endfunction

endpackage

// File: rtl/matriz_leds_scan_detector_borda.sv
// Per-button 2-FF synchroniser with rising-edge pulse, blind to levels held through reset.
module detector_borda (
  input  logic clk,
  input  logic rst,
  input  logic botao,
  output logic pulso_c
);

  logic sync1, sync2, prev, armed;
  logic [1:0] fill;

  // armed only goes high once the sync chain carries real samples showing the button low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= botao;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & ~sync2);
    end
  end

  assign pulso_c = sync2 & ~prev & armed;

endmodule

// File: rtl/matriz_leds_scan.sv
// LED-matrix puzzle core: press-driven region toggles, move count, win lock and row scan.
module matriz_leds_scan
  import matriz_pkg::*;
#(
  parameter int unsigned ROWS     = 8,
  parameter int unsigned COLS     = 8,
  parameter int unsigned NUM_BTNS = 8,
  parameter int unsigned SCAN_DIV = 1,
  parameter int unsigned MOV_W    = 8,
  parameter int unsigned LVL_W    = 3,
  parameter logic [NUM_BTNS*ROWS*COLS-1:0] BTN_MASKS = DEF_BTN_MASKS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_BTNS-1:0]      botoes,
  input  logic [LVL_W-1:0]         nivel,
  input  logic                     limpar,
  output logic [COLS-1:0]          colunas,
  output logic [$clog2(ROWS)-1:0]  linhas,
  output logic                     nivel_concluido,
  output logic [MOV_W-1:0]         jogadas,
  output logic [$clog2(ROWS)-1:0]  db_linha
);

  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned CELLS = ROWS * COLS;
  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [ROWS-1:0][COLS-1:0] estado;
  logic [ROWS-1:0][COLS-1:0] mask_sel;
  logic [NUM_BTNS-1:0]       pulso;
  logic                      sel_valid;
  logic                      aceita;
  logic                      concluido_c;
  logic [PRE_W-1:0]          presc;

  for (genvar k = 0; k < NUM_BTNS; k++) begin : g_det
    detector_borda u_det (
      .clk     (clk),
      .rst     (rst),
      .botao   (botoes[k]),
      .pulso_c (pulso[k])
    );
  end

  // Lowest-index pulse wins; the loop runs high to low so the last hit is the lowest.
  always_comb begin
    mask_sel  = '0;
    sel_valid = 1'b0;
    for (int k = int'(NUM_BTNS) - 1; k >= 0; k--) begin
      if (pulso[k]) begin
        mask_sel  = BTN_MASKS[k*int'(CELLS) +: CELLS];
        sel_valid = 1'b1;
      end
    end
  end

  assign aceita = sel_valid & ~nivel_concluido & ~limpar;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado  <= '0;
      jogadas <= '0;
    end else if (limpar) begin
      estado  <= '0;
      jogadas <= '0;
    end else if (aceita) begin
      estado <= estado ^ mask_sel;
      if (jogadas != {MOV_W{1'b1}})
        jogadas <= jogadas + MOV_W'(1);
    end
  end

  // Required leading rows all lit; remaining rows are don't-care.
  always_comb begin
    concluido_c = 1'b1;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if ((r < win_rows(ROWS, 32'(nivel))) && (estado[r] != {COLS{1'b1}}))
        concluido_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) nivel_concluido <= 1'b0;
    else     nivel_concluido <= concluido_c;
  end

  // Row scan: prescaler wrap advances the row, which wraps after ROWS-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      linhas <= '0;
    end else if (presc == PRE_W'(SCAN_DIV - 1)) begin
      presc  <= '0;
      linhas <= (linhas == ROW_W'(ROWS - 1)) ? '0 : linhas + ROW_W'(1);
    end else begin
      presc <= presc + PRE_W'(1);
    end
  end

  always_comb begin
    colunas = '0;
    for (int unsigned r = 0; r < ROWS; r++)
      if (linhas == ROW_W'(r)) colunas = estado[r];
  end

  assign db_linha = linhas;

endmodule
